// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM (Moore), stretchable memory states.
// Optional LUI/AUIPC support via `define MC_CTRL_UPPER_IMM_EN.
module mc_control_fsm #(
   parameter int MEM_LAT = 0,
   parameter int ST_W    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [6:0]      OP_Code,
   input  logic [2:0]      Funct3,
   input  logic            Zero,
   output logic            PCWrite,
   output logic            AdrSrc,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            RegWrite,
   output logic [1:0]      ResultSrc,
   output logic [1:0]      ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      ALUOp,
   output logic [2:0]      ImmSrc,
   output logic            Illegal,
   output logic            InstrDone,
   output logic [ST_W-1:0] State
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
`ifdef MC_CTRL_UPPER_IMM_EN
      LINK     = 4'd12,
      UPPER    = 4'd13
`else
      LINK     = 4'd12
`endif
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] wait_q;
   logic       last;
   logic       pc_upd, br_take;
   logic       mem_wr, ir_wr, reg_wr, ill, done;

   assign last = (wait_q == 4'(MEM_LAT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) wait_q <= '0;
         else                    wait_q <= wait_q + 4'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_upd    = 1'b0;
      mem_wr    = 1'b0;
      ir_wr     = 1'b0;
      reg_wr    = 1'b0;
      ill       = 1'b0;
      done      = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      case (state_q)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (last) begin
               ir_wr   = 1'b1;
               pc_upd  = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (OP_Code)
               7'b0000011,
               7'b0100011: state_d = MEMADR;
               7'b0110011: state_d = EXECR;
               7'b0010011: state_d = EXECI;
               7'b1100011: state_d = BRANCH;
               7'b1101111: state_d = JAL;
               7'b1100111: state_d = JALR;
`ifdef MC_CTRL_UPPER_IMM_EN
               7'b0110111,
               7'b0010111: state_d = UPPER;
`endif
               default: begin
                  state_d = FETCH;
                  ill     = 1'b1;
                  done    = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (OP_Code == 7'b0000011) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (last) state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            reg_wr    = 1'b1;
            done      = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_wr = 1'b1;
            if (last) begin
               done    = 1'b1;
               state_d = FETCH;
            end
         end
         EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            state_d = ALUWB;
         end
         EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            state_d = ALUWB;
         end
         ALUWB: begin
            reg_wr  = 1'b1;
            done    = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            done    = 1'b1;
            state_d = FETCH;
         end
         JAL: begin
            pc_upd  = 1'b1;
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            state_d = ALUWB;
         end
         JALR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            pc_upd    = 1'b1;
            state_d   = LINK;
         end
         LINK: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            state_d = ALUWB;
         end
`ifdef MC_CTRL_UPPER_IMM_EN
         UPPER: begin
            ALUSrcA = (OP_Code == 7'b0110111) ? 2'b11 : 2'b01;
            ALUSrcB = 2'b01;
            state_d = ALUWB;
         end
`endif
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      ImmSrc = 3'b000;
      case (OP_Code)
         7'b0100011: ImmSrc = 3'b001;
         7'b1100011: ImmSrc = 3'b010;
         7'b1101111: ImmSrc = 3'b011;
`ifdef MC_CTRL_UPPER_IMM_EN
         7'b0110111,
         7'b0010111: ImmSrc = 3'b100;
`endif
         default:    ImmSrc = 3'b000;
      endcase
   end

   assign br_take = (state_q == BRANCH) &&
                    (((Funct3 == 3'b000) && Zero) ||
                     ((Funct3 == 3'b001) && !Zero));

   // Gate with rst_n so FETCH's last-cycle strobes stay low while held in reset
   assign PCWrite   = rst_n & (pc_upd | br_take);
   assign MemWrite  = rst_n & mem_wr;
   assign IRWrite   = rst_n & ir_wr;
   assign RegWrite  = rst_n & reg_wr;
   assign Illegal   = rst_n & ill;
   assign InstrDone = rst_n & done;

   always_comb begin
      State      = '0;
      State[3:0] = state_q;
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with MEM_LAT=0 and MEM_LAT=2 instances.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'b0;
   logic [2:0] f3 = 3'b0;
   logic       zero = 1'b0;

   logic       pcw0, adr0, mw0, irw0, rw0, ill0, done0;
   logic [1:0] rs0, sa0, sb0, aop0;
   logic [2:0] imm0;
   logic [3:0] st0;
   logic       pcw2, adr2, mw2, irw2, rw2, ill2, done2;
   logic [1:0] rs2, sa2, sb2, aop2;
   logic [2:0] imm2;
   logic [3:0] st2;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mc_control_fsm #(.MEM_LAT(0), .ST_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .OP_Code(op), .Funct3(f3), .Zero(zero),
      .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0),
      .RegWrite(rw0), .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0),
      .ALUOp(aop0), .ImmSrc(imm0), .Illegal(ill0), .InstrDone(done0),
      .State(st0)
   );

   mc_control_fsm #(.MEM_LAT(2), .ST_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .OP_Code(op), .Funct3(f3), .Zero(zero),
      .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2),
      .RegWrite(rw2), .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2),
      .ALUOp(aop2), .ImmSrc(imm2), .Illegal(ill2), .InstrDone(done2),
      .State(st2)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step();
      vecs++;
      if ({st0, pcw0, irw0, mw0, rw0, ill0, done0} !== 10'b0) begin
         $display("FAIL rst_lat0 got st=%0d pcw=%b irw=%b mw=%b rw=%b ill=%b done=%b want all 0",
                  st0, pcw0, irw0, mw0, rw0, ill0, done0);
         errs++;
      end
      vecs++;
      if ({sb0, rs0, sa0, aop0, adr0} !== 9'b10_10_00_00_0) begin
         $display("FAIL rst_mux got sb=%b rs=%b sa=%b op=%b adr=%b want sb=10 rs=10 sa=00 op=00 adr=0",
                  sb0, rs0, sa0, aop0, adr0);
         errs++;
      end
      vecs++;
      if ({st2, irw2, pcw2} !== 6'b0) begin
         $display("FAIL rst_lat2 got st=%0d irw=%b pcw=%b want 0", st2, irw2, pcw2);
         errs++;
      end
   endtask

   task automatic test_add;
      do_reset();
      op = 7'b0110011; f3 = 3'b000; zero = 1'b0;
      #1;
      vecs++;
      if ({st0, irw0, pcw0, rw0} !== {4'd0, 3'b110}) begin
         $display("FAIL add_fetch got st=%0d irw=%b pcw=%b rw=%b want 0 1 1 0",
                  st0, irw0, pcw0, rw0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, sa0, sb0, ill0, rw0} !== {4'd1, 2'b01, 2'b01, 2'b00}) begin
         $display("FAIL add_decode got st=%0d sa=%b sb=%b ill=%b rw=%b want 1 01 01 0 0",
                  st0, sa0, sb0, ill0, rw0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, sa0, sb0, aop0, rw0} !== {4'd6, 2'b10, 2'b00, 2'b10, 1'b0}) begin
         $display("FAIL add_execr got st=%0d sa=%b sb=%b aop=%b rw=%b want 6 10 00 10 0",
                  st0, sa0, sb0, aop0, rw0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, rw0, done0, rs0} !== {4'd8, 2'b11, 2'b00}) begin
         $display("FAIL add_aluwb got st=%0d rw=%b done=%b rs=%b want 8 1 1 00",
                  st0, rw0, done0, rs0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, rw0, done0} !== {4'd0, 2'b00}) begin
         $display("FAIL add_next got st=%0d rw=%b done=%b want 0 0 0", st0, rw0, done0);
         errs++;
      end
   endtask

   task automatic test_lw_latency;
      logic [3:0] st_e [10];
      logic       irw_e [10];
      logic       rw_e [10];
      logic       adr_e [10];
      st_e  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
      irw_e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      rw_e  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      adr_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      op = 7'b0000011; f3 = 3'b010; zero = 1'b0;
      #1;
      for (int i = 0; i < 10; i++) begin
         vecs++;
         if ({st2, irw2, rw2, adr2} !== {st_e[i], irw_e[i], rw_e[i], adr_e[i]}) begin
            $display("FAIL lw_cyc%0d got st=%0d irw=%b rw=%b adr=%b want st=%0d irw=%b rw=%b adr=%b",
                     i, st2, irw2, rw2, adr2, st_e[i], irw_e[i], rw_e[i], adr_e[i]);
            errs++;
         end
         if (i == 8) begin
            vecs++;
            if ({done2, rs2, imm2} !== {1'b1, 2'b01, 3'b000}) begin
               $display("FAIL lw_memwb got done=%b rs=%b imm=%b want 1 01 000",
                        done2, rs2, imm2);
               errs++;
            end
         end
         if (i < 9) step();
      end
   endtask

   task automatic test_branch;
      do_reset();
      op = 7'b1100011; f3 = 3'b000; zero = 1'b1;
      step();
      vecs++;
      if ({st0, imm0, pcw0} !== {4'd1, 3'b010, 1'b0}) begin
         $display("FAIL br_decode got st=%0d imm=%b pcw=%b want 1 010 0", st0, imm0, pcw0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, pcw0, done0, aop0, sa0} !== {4'd9, 2'b11, 2'b01, 2'b10}) begin
         $display("FAIL beq_taken got st=%0d pcw=%b done=%b aop=%b sa=%b want 9 1 1 01 10",
                  st0, pcw0, done0, aop0, sa0);
         errs++;
      end
      f3 = 3'b001; #1;
      vecs++;
      if (pcw0 !== 1'b0) begin
         $display("FAIL bne_zero got pcw=%b want 0", pcw0);
         errs++;
      end
      zero = 1'b0; #1;
      vecs++;
      if (pcw0 !== 1'b1) begin
         $display("FAIL bne_nzero got pcw=%b want 1", pcw0);
         errs++;
      end
      f3 = 3'b100; #1;
      vecs++;
      if (pcw0 !== 1'b0) begin
         $display("FAIL blt_ignored got pcw=%b want 0", pcw0);
         errs++;
      end
      f3 = 3'b000; #1;
      vecs++;
      if (pcw0 !== 1'b0) begin
         $display("FAIL beq_nzero got pcw=%b want 0", pcw0);
         errs++;
      end
      step();
      vecs++;
      if (st0 !== 4'd0) begin
         $display("FAIL br_next got st=%0d want 0", st0);
         errs++;
      end
   endtask

   task automatic test_jalr;
      do_reset();
      op = 7'b1100111; f3 = 3'b000; zero = 1'b0;
      step();
      vecs++;
      if ({st0, imm0} !== {4'd1, 3'b000}) begin
         $display("FAIL jalr_decode got st=%0d imm=%b want 1 000", st0, imm0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, pcw0, rw0, rs0, sa0, sb0} !== {4'd11, 2'b10, 2'b10, 2'b10, 2'b01}) begin
         $display("FAIL jalr_state got st=%0d pcw=%b rw=%b rs=%b sa=%b sb=%b want 11 1 0 10 10 01",
                  st0, pcw0, rw0, rs0, sa0, sb0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, pcw0, rw0, sa0, sb0} !== {4'd12, 2'b00, 2'b01, 2'b10}) begin
         $display("FAIL jalr_link got st=%0d pcw=%b rw=%b sa=%b sb=%b want 12 0 0 01 10",
                  st0, pcw0, rw0, sa0, sb0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, pcw0, rw0, done0} !== {4'd8, 3'b011}) begin
         $display("FAIL jalr_wb got st=%0d pcw=%b rw=%b done=%b want 8 0 1 1",
                  st0, pcw0, rw0, done0);
         errs++;
      end
   endtask

   task automatic test_illegal;
      do_reset();
      op = 7'b1111111;
      step();
      vecs++;
      if ({st0, ill0, done0, pcw0, mw0, irw0, rw0} !== {4'd1, 6'b110000}) begin
         $display("FAIL ill_decode got st=%0d ill=%b done=%b pcw=%b mw=%b irw=%b rw=%b want 1 1 1 0 0 0 0",
                  st0, ill0, done0, pcw0, mw0, irw0, rw0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, ill0, done0} !== {4'd0, 2'b00}) begin
         $display("FAIL ill_next got st=%0d ill=%b done=%b want 0 0 0", st0, ill0, done0);
         errs++;
      end
      do_reset();
      op = 7'b0110111;
      step();
`ifdef MC_CTRL_UPPER_IMM_EN
      vecs++;
      if ({ill0, imm0} !== {1'b0, 3'b100}) begin
         $display("FAIL lui_decode got ill=%b imm=%b want 0 100", ill0, imm0);
         errs++;
      end
      step();
      vecs++;
      if ({st0, sa0, sb0} !== {4'd13, 2'b11, 2'b01}) begin
         $display("FAIL lui_upper got st=%0d sa=%b sb=%b want 13 11 01", st0, sa0, sb0);
         errs++;
      end
`else
      vecs++;
      if ({ill0, done0, imm0} !== {2'b11, 3'b000}) begin
         $display("FAIL lui_illegal got ill=%b done=%b imm=%b want 1 1 000",
                  ill0, done0, imm0);
         errs++;
      end
      step();
      vecs++;
      if (st0 !== 4'd0) begin
         $display("FAIL lui_next got st=%0d want 0", st0);
         errs++;
      end
`endif
   endtask

   task automatic test_store_reset;
      do_reset();
      op = 7'b0100011; f3 = 3'b010;
      for (int i = 0; i < 5; i++) step();
      vecs++;
      if ({st2, mw2, adr2, imm2} !== {4'd5, 2'b11, 3'b001}) begin
         $display("FAIL sw_cyc1 got st=%0d mw=%b adr=%b imm=%b want 5 1 1 001",
                  st2, mw2, adr2, imm2);
         errs++;
      end
      step();
      vecs++;
      if ({st2, mw2, done2} !== {4'd5, 2'b10}) begin
         $display("FAIL sw_cyc2 got st=%0d mw=%b done=%b want 5 1 0", st2, mw2, done2);
         errs++;
      end
      rst_n = 1'b0;
      #1;
      vecs++;
      if ({st2, mw2, irw2, pcw2, rw2} !== {4'd0, 4'b0000}) begin
         $display("FAIL sw_abort got st=%0d mw=%b irw=%b pcw=%b rw=%b want 0 0 0 0 0",
                  st2, mw2, irw2, pcw2, rw2);
         errs++;
      end
      step();
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         vecs++;
         if ({st2, irw2} !== {4'd0, (i == 2)}) begin
            $display("FAIL rel_fetch%0d got st=%0d irw=%b want 0 %b", i, st2, irw2, (i == 2));
            errs++;
         end
         step();
      end
      vecs++;
      if (st2 !== 4'd1) begin
         $display("FAIL rel_decode got st=%0d want 1", st2);
         errs++;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_latency();
      test_branch();
      test_jalr();
      test_illegal();
      test_store_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_LAT, default 0, extra wait cycles per memory access (legal 0..15).
REQ-002 Parameter ST_W, default 4, width of the State debug output (legal values ≥4).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 OP_Code  input  7  opcode of the latched instruction register.
REQ-006 Funct3  input  3  funct3 of the latched instruction.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 Control outputs, each output  1: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite.
REQ-009 Control outputs, each output  2: ResultSrc, ALUSrcA, ALUSrcB, ALUOp.
REQ-010 ImmSrc  output  3  immediate type: I=000, S=001, B=010, J=011, U=100.
REQ-011 Status outputs, each output  1: Illegal (one-cycle pulse), InstrDone (one-cycle pulse).
REQ-012 State  output  ST_W  current state code, zero-extended.

Function
REQ-013 The block SHALL be a Moore FSM; all controls except PCWrite SHALL decode from state only.
REQ-014 The state codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LINK=12, UPPER=13.
REQ-015 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=1 and PCUpdate=1 on its last cycle only.
REQ-016 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 and SHALL branch on OP_Code: 0000011/0100011→MEMADR, 0110011→EXECR, 0010011→EXECI, 1100011→BRANCH, 1101111→JAL, 1100111→JALR, 0110111/0010111→UPPER; any other opcode→FETCH with Illegal=1 for that cycle.
REQ-017 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MEMREAD for a load and MEMWRITE for a store.
REQ-018 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00 and go to MEMWB; MEMWB SHALL drive ResultSrc=01, RegWrite=1 and go to FETCH.
REQ-019 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1 on every cycle, then go to FETCH.
REQ-020 EXECR (ALUSrcB=00) and EXECI (ALUSrcB=01) SHALL drive ALUSrcA=10, ALUOp=10 and go to ALUWB; ALUWB SHALL drive ResultSrc=00, RegWrite=1 and go to FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00 and go to FETCH.
REQ-022 PCWrite SHALL equal PCUpdate OR (state==BRANCH AND Funct3==000 AND Zero) OR (state==BRANCH AND Funct3==001 AND !Zero); other Funct3 values SHALL never take the branch.
REQ-023 JAL SHALL drive ResultSrc=00, PCUpdate=1, ALUSrcA=01, ALUSrcB=10, ALUOp=00, then go to ALUWB.
REQ-024 JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1, then go to LINK.
REQ-025 LINK SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, then go to ALUWB.
REQ-026 UPPER SHALL drive ALUSrcB=01, ALUOp=00, with ALUSrcA=11 (zero) for LUI and 01 (OldPC) for AUIPC, then go to ALUWB.
REQ-027 ImmSrc SHALL decode combinationally from OP_Code: load/OP-IMM/JALR→I, store→S, branch→B, JAL→J, LUI/AUIPC→U, else 000.
REQ-028 FETCH, MEMREAD and MEMWRITE SHALL each last MEM_LAT+1 cycles, timed by an internal wait counter that clears on every state change; outputs SHALL hold across wait cycles.
REQ-029 All other states SHALL last exactly one cycle.
REQ-030 InstrDone SHALL pulse in the last cycle of any state whose next state is FETCH, including the illegal-opcode DECODE cycle.
REQ-031 Unused outputs in a state SHALL be 0, never x.
REQ-032 An unreachable state code SHALL go to FETCH with all write enables 0.

Reset
REQ-033 While rst_n=0: state=FETCH, wait counter=0, PCWrite/MemWrite/IRWrite/RegWrite/Illegal/InstrDone=0, mux selects at FETCH values.
REQ-034 Reset asserted mid-instruction SHALL abort it at once with no further write enable asserted.
REQ-035 The first FETCH after reset release SHALL last a full MEM_LAT+1 cycles.

Configuration
REQ-036 With macro MC_CTRL_UPPER_IMM_EN defined, LUI/AUIPC SHALL decode to UPPER as in REQ-016.
REQ-037 Without MC_CTRL_UPPER_IMM_EN, the UPPER state SHALL be absent, opcodes 0110111/0010111 SHALL be illegal, and ImmSrc SHALL never be 100.

Verification
REQ-038 MEM_LAT=0, add (0110011): states 0,1,6,8,0; RegWrite=1 only in ALUWB; instruction completes in 4 cycles.
REQ-039 MEM_LAT=2, lw (0000011): FETCH lasts 3 cycles with IRWrite=1 only in the 3rd; MEMREAD lasts 3 cycles; instruction completes in 9 cycles.
REQ-040 beq with Zero=1 → PCWrite=1 in BRANCH; bne with Zero=1 → PCWrite=0; Funct3=100 → PCWrite=0.
REQ-041 jalr (1100111): states 1→11→12→8; PCWrite=1 in JALR; RegWrite=1 in ALUWB only.
REQ-042 OP_Code=1111111 → Illegal and InstrDone pulse in DECODE, next state 0, no write enable asserted.
REQ-043 Drive rst_n low during MEMWRITE cycle 2 of 3 (MEM_LAT=2) → MemWrite drops immediately; State=0 on release.
